// File: rtl/ve_div_pkg.sv
// ve_div_pkg: shared types and elaboration helpers for the ve_div32 divider.
// Holds the FSM state enum, the legal STEPS mask and the iteration-counter width helper.
// No ports; imported by ve_div_step and ve_div32.
package ve_div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } div_state_t;

  // Bit n set means STEPS == n is a supported unroll factor (1, 2, 4).
  localparam logic [4:0] LEGAL_STEPS_MASK = 5'b10110;

  function automatic bit steps_legal(input int width, input int steps);
    if (steps < 1 || steps > 4) return 1'b0;
    return LEGAL_STEPS_MASK[steps] && ((width % steps) == 0);
  endfunction

  // Counter must hold WIDTH/STEPS, the value loaded on accept.
  function automatic int count_width(input int width, input int steps);
    return $clog2(width / steps + 1);
  endfunction

endpackage

// File: rtl/ve_div_step.sv
// ve_div_step: one combinational shift-compare-subtract stage of a restoring divider.
// Ports: rem (WIDTH+1, partial remainder, always < divisor), q (WIDTH, dividend low / quotient
// shift register), divisor (WIDTH); next_rem, next_q are the values after one quotient bit.
module ve_div_step
  import ve_div_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH:0]   rem,
  input  logic [WIDTH-1:0] q,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH:0]   next_rem,
  output logic [WIDTH-1:0] next_q
);

  logic [WIDTH+1:0] shifted;
  logic [WIDTH+1:0] diff;
  logic             fits;

  // rem < divisor, so the shifted value is below 2^(WIDTH+1); one extra bit on the
  // subtraction makes its top bit a clean borrow flag.
  assign shifted  = {rem, q[WIDTH-1]};
  assign diff     = shifted - {2'b00, divisor};
  assign fits     = ~diff[WIDTH+1];
  assign next_rem = fits ? diff[WIDTH:0] : shifted[WIDTH:0];
  assign next_q   = {q[WIDTH-2:0], fits};

endmodule

// File: rtl/ve_div32.sv
// ve_div32: sequential restoring divider, 2*WIDTH-bit dividend / WIDTH-bit divisor,
// STEPS quotient bits per cycle; valid/ready on both sides, no overlap between operations.
// Ports: clk, rst_n (async active-low); in_valid/in_ready + dividend/divisor;
// out_valid/out_ready + quotient/remainder/div0/ovf; chk_fail (self-check result).
// Latency: out_valid WIDTH/STEPS cycles after the accept edge; div0/ovf results register
// on the accept edge itself. Results hold stable in DONE until out_ready.
// Optional macro VE_DIV_VERIFY_EN: in DONE, recompute quotient*divisor+remainder and flag
// chk_fail on mismatch with the latched dividend; undefined, chk_fail is tied low.
module ve_div32
  import ve_div_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int STEPS = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [2*WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0]   divisor,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   quotient,
  output logic [WIDTH-1:0]   remainder,
  output logic               div0,
  output logic               ovf,
  output logic               chk_fail
);

  localparam int NCYC = WIDTH / STEPS;
  localparam int CW   = count_width(WIDTH, STEPS);

  if (!steps_legal(WIDTH, STEPS)) begin : g_bad_steps
    $error("ve_div32: STEPS must be 1, 2 or 4 and divide WIDTH");
  end

  div_state_t       state, state_nxt;
  logic [WIDTH:0]   rem_r, rem_nxt;
  logic [WIDTH-1:0] q_r, q_nxt;
  logic [WIDTH-1:0] dvs_r, dvs_nxt;
  logic [CW-1:0]    cnt_r, cnt_nxt;
  logic             div0_r, div0_nxt;
  logic             ovf_r, ovf_nxt;

  // Unrolled chain: element 0 is the registered state, element STEPS the value after
  // this cycle's STEPS quotient bits.
  logic [WIDTH:0]   rem_c [STEPS+1];
  logic [WIDTH-1:0] q_c   [STEPS+1];

  assign rem_c[0] = rem_r;
  assign q_c[0]   = q_r;

  for (genvar g = 0; g < STEPS; g++) begin : g_step
    ve_div_step #(.WIDTH(WIDTH)) u_step (
      .rem      (rem_c[g]),
      .q        (q_c[g]),
      .divisor  (dvs_r),
      .next_rem (rem_c[g+1]),
      .next_q   (q_c[g+1])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      rem_r  <= '0;
      q_r    <= '0;
      dvs_r  <= '0;
      cnt_r  <= '0;
      div0_r <= 1'b0;
      ovf_r  <= 1'b0;
    end else begin
      state  <= state_nxt;
      rem_r  <= rem_nxt;
      q_r    <= q_nxt;
      dvs_r  <= dvs_nxt;
      cnt_r  <= cnt_nxt;
      div0_r <= div0_nxt;
      ovf_r  <= ovf_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    rem_nxt   = rem_r;
    q_nxt     = q_r;
    dvs_nxt   = dvs_r;
    cnt_nxt   = cnt_r;
    div0_nxt  = div0_r;
    ovf_nxt   = ovf_r;
    unique case (state)
      IDLE: begin
        if (in_valid) begin
          div0_nxt = 1'b0;
          ovf_nxt  = 1'b0;
          dvs_nxt  = divisor;
          if (divisor == '0) begin
            div0_nxt  = 1'b1;
            q_nxt     = '1;
            rem_nxt   = {1'b0, dividend[WIDTH-1:0]};
            state_nxt = DONE;
          end else if (dividend[2*WIDTH-1:WIDTH] >= divisor) begin
            // Quotient would need more than WIDTH bits.
            ovf_nxt   = 1'b1;
            q_nxt     = '1;
            rem_nxt   = '0;
            state_nxt = DONE;
          end else begin
            rem_nxt   = {1'b0, dividend[2*WIDTH-1:WIDTH]};
            q_nxt     = dividend[WIDTH-1:0];
            cnt_nxt   = CW'(NCYC);
            state_nxt = BUSY;
          end
        end
      end
      BUSY: begin
        rem_nxt = rem_c[STEPS];
        q_nxt   = q_c[STEPS];
        cnt_nxt = cnt_r - CW'(1);
        if (cnt_r == CW'(1)) state_nxt = DONE;
      end
      DONE: begin
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  // Partial quotient/remainder bits never leave the block.
  assign quotient  = out_valid ? q_r : '0;
  assign remainder = out_valid ? rem_r[WIDTH-1:0] : '0;
  assign div0      = div0_r;
  assign ovf       = ovf_r;

`ifdef VE_DIV_VERIFY_EN
  logic [2*WIDTH-1:0] dvd_r;
  logic [2*WIDTH-1:0] recon;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dvd_r <= '0;
    end else if (state == IDLE && in_valid) begin
      dvd_r <= dividend;
    end
  end

  assign recon    = {{WIDTH{1'b0}}, q_r} * {{WIDTH{1'b0}}, dvs_r} + {{WIDTH{1'b0}}, rem_r[WIDTH-1:0]};
  assign chk_fail = (state == DONE) && !div0_r && !ovf_r && (recon != dvd_r);
`else
  assign chk_fail = 1'b0;
`endif

endmodule

// File: tb/tb_ve_div32.sv
// tb_ve_div32: self-checking bench for ve_div32; runs a STEPS=1 and a STEPS=4 instance side
// by side on shared stimulus, checks every cycle against an arithmetic reference model,
// plus directed literal cases, backpressure, and reset in the middle of an operation.
module tb_ve_div32;

  typedef struct packed {
    logic        d0;
    logic        ov;
    logic [31:0] q;
    logic [31:0] r;
  } res_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [63:0] dividend = '0;
  logic [31:0] divisor = '0;

  logic        in_ready_o  [2];
  logic        out_valid_o [2];
  logic        div0_o      [2];
  logic        ovf_o       [2];
  logic        chk_o       [2];
  logic [31:0] quot_o      [2];
  logic [31:0] rem_o       [2];

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;

  // Per-instance expectation state.
  int   lat_of [2] = '{32, 8};
  bit   pend   [2];
  int   acc    [2];
  int   exp_lat[2];
  res_t exp_res[2];

  ve_div32 #(.WIDTH(32), .STEPS(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_o[0]),
    .dividend(dividend), .divisor(divisor), .out_valid(out_valid_o[0]), .out_ready(out_ready),
    .quotient(quot_o[0]), .remainder(rem_o[0]), .div0(div0_o[0]), .ovf(ovf_o[0]),
    .chk_fail(chk_o[0])
  );

  ve_div32 #(.WIDTH(32), .STEPS(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_o[1]),
    .dividend(dividend), .divisor(divisor), .out_valid(out_valid_o[1]), .out_ready(out_ready),
    .quotient(quot_o[1]), .remainder(rem_o[1]), .div0(div0_o[1]), .ovf(ovf_o[1]),
    .chk_fail(chk_o[1])
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic res_t model(input logic [63:0] dvd, input logic [31:0] dvs);
    res_t m;
    m = '0;
    if (dvs == 32'd0) begin
      m.d0 = 1'b1;
      m.q  = 32'hFFFF_FFFF;
      m.r  = dvd[31:0];
    end else if (dvd[63:32] >= dvs) begin
      m.ov = 1'b1;
      m.q  = 32'hFFFF_FFFF;
    end else begin
      m.q = 32'(dvd / {32'd0, dvs});
      m.r = 32'(dvd % {32'd0, dvs});
    end
    return m;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Compare process: outputs sampled mid-cycle, then the model advances for the next edge.
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (!rst_n) begin
        chk($sformatf("rst%0d in_ready", i), in_ready_o[i], 1);
        chk($sformatf("rst%0d out_valid", i), out_valid_o[i], 0);
        chk($sformatf("rst%0d quotient", i), quot_o[i], 0);
        chk($sformatf("rst%0d remainder", i), rem_o[i], 0);
        chk($sformatf("rst%0d div0", i), div0_o[i], 0);
        chk($sformatf("rst%0d ovf", i), ovf_o[i], 0);
        chk($sformatf("rst%0d chk_fail", i), chk_o[i], 0);
        pend[i] = 1'b0;
      end else begin
        bit ev;
        ev = pend[i] && ((cyc - acc[i]) >= exp_lat[i]);
        chk($sformatf("s%0d in_ready", i), in_ready_o[i], !pend[i]);
        chk($sformatf("s%0d out_valid", i), out_valid_o[i], ev);
        chk($sformatf("s%0d chk_fail", i), chk_o[i], 0);
        if (ev) begin
          chk($sformatf("s%0d quotient", i), quot_o[i], exp_res[i].q);
          chk($sformatf("s%0d remainder", i), rem_o[i], exp_res[i].r);
          chk($sformatf("s%0d div0", i), div0_o[i], exp_res[i].d0);
          chk($sformatf("s%0d ovf", i), ovf_o[i], exp_res[i].ov);
        end
        if (!pend[i] && in_valid) begin
          exp_res[i] = model(dividend, divisor);
          pend[i]    = 1'b1;
          acc[i]     = cyc + 1;
          // Error results are registered on the accept edge itself.
          exp_lat[i] = (exp_res[i].d0 || exp_res[i].ov) ? 0 : lat_of[i];
        end else if (ev && out_ready) begin
          pend[i] = 1'b0;
        end
      end
    end
  end

  task automatic op(input logic [63:0] dvd, input logic [31:0] dvs, input int hold,
                    input bit pulse, input bit lit, input logic [31:0] lq,
                    input logic [31:0] lr, input logic ld0, input logic lov);
    int n;
    n = 0;
    while (!(in_ready_o[0] && in_ready_o[1]) && n < 100) begin
      @(posedge clk); #2; n++;
    end
    chk("wait in_ready within budget", (n < 100), 1);
    dividend = dvd;
    divisor  = dvs;
    in_valid = 1'b1;
    @(posedge clk); #2;
    in_valid = 1'b0;
    // Scramble the bus: the result must come from the operands latched at accept.
    dividend = {$urandom, $urandom};
    divisor  = $urandom;
    n = 0;
    while (!(out_valid_o[0] && out_valid_o[1]) && n < 100) begin
      in_valid = pulse & n[0];
      @(posedge clk); #2; n++;
    end
    in_valid = 1'b0;
    chk("wait out_valid within budget", (n < 100), 1);
    for (int k = 0; k < hold; k++) begin
      in_valid = pulse & ~in_valid;
      @(posedge clk); #2;
    end
    in_valid = 1'b0;
    if (lit) begin
      for (int i = 0; i < 2; i++) begin
        chk($sformatf("lit%0d quotient", i), quot_o[i], lq);
        chk($sformatf("lit%0d remainder", i), rem_o[i], lr);
        chk($sformatf("lit%0d div0", i), div0_o[i], ld0);
        chk($sformatf("lit%0d ovf", i), ovf_o[i], lov);
      end
    end
    out_ready = 1'b1;
    @(posedge clk); #2;
    out_ready = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not reach the end");
    $fatal(1, "watchdog expired");
  end

  initial begin
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk); #2;

    op(64'h64, 32'd7, 0, 1'b0, 1'b1, 32'd14, 32'd2, 1'b0, 1'b0);
    op(64'hFFFF_FFFE_0000_0001, 32'hFFFF_FFFF, 0, 1'b0, 1'b1, 32'hFFFF_FFFF, 32'd0, 1'b0, 1'b0);
    op(64'h1234_5678_9ABC_DEF0, 32'd0, 0, 1'b0, 1'b1, 32'hFFFF_FFFF, 32'h9ABC_DEF0, 1'b1, 1'b0);
    op(64'h0000_0005_0000_0000, 32'd5, 0, 1'b0, 1'b1, 32'hFFFF_FFFF, 32'd0, 1'b0, 1'b1);
    op(64'h0000_0004_FFFF_FFFF, 32'd5, 0, 1'b0, 1'b1, 32'hFFFF_FFFF, 32'd4, 1'b0, 1'b0);
    // Backpressure with in_valid pulses while busy/done: 1000003 = 17*58823 + 12.
    op(64'd1000003, 32'd17, 10, 1'b1, 1'b1, 32'd58823, 32'd12, 1'b0, 1'b0);

    // Reset at BUSY cycle 10 (the STEPS=4 instance is already holding in DONE).
    dividend = 64'h0000_1234_FFFF_0000;
    divisor  = 32'h0001_0000;
    in_valid = 1'b1;
    @(posedge clk); #2;
    in_valid = 1'b0;
    repeat (9) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("async%0d out_valid", i), out_valid_o[i], 0);
      chk($sformatf("async%0d in_ready", i), in_ready_o[i], 1);
      chk($sformatf("async%0d quotient", i), quot_o[i], 0);
      chk($sformatf("async%0d remainder", i), rem_o[i], 0);
    end
    @(posedge clk); #2 rst_n = 1'b1;
    @(posedge clk); #2;
    op(64'd1000, 32'd3, 0, 1'b0, 1'b1, 32'd333, 32'd1, 1'b0, 1'b0);

    for (int t = 0; t < 24; t++) begin
      logic [31:0] hi, lo, dv;
      int kind;
      kind = $urandom_range(7, 0);
      lo   = $urandom;
      if (kind == 0) begin
        dv = 32'd0;
        hi = $urandom;
      end else if (kind == 1) begin
        hi = $urandom | 32'd1;
        dv = $urandom_range(hi, 1);
      end else if (kind == 2) begin
        dv = $urandom_range(255, 1);
        hi = $urandom % dv;
      end else begin
        dv = $urandom | 32'd1;
        hi = $urandom % dv;
      end
      op({hi, lo}, dv, $urandom_range(3, 0), 1'($urandom_range(1, 0)), 1'b0,
         32'd0, 32'd0, 1'b0, 1'b0);
    end

    repeat (2) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
